pixel_tx_disassembly: RTL

Reads a stored RGB frame out of the frame buffer one 24-bit pixel at a time, splits each pixel into three bytes and serialises them on a UART TX line (8N1). It is the transmit counterpart of the RX byte-to-pixel assembly path: a frame received and processed on the FPGA can be streamed back to the host in the same byte order. It sits between the frame-buffer read port and the board's UART TX pin.

---
 rtl/pixel_tx_disassembly_pkg.sv | 43 ++++
 rtl/pixel_tx_disassembly_if.sv | 31 +++
 rtl/pixel_tx_disassembly_uart_tx.sv | 67 ++++++
 rtl/pixel_tx_disassembly.sv | 121 ++++++++++++
 4 files changed

// File: rtl/pixel_tx_disassembly_pkg.sv
// ============================================================================
// pixel_tx_disassembly_pkg : shared UART/pixel types, constants and helpers
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_tx_disassembly_pkg;

    localparam int PIX_W  = 24;
    localparam int ADDR_W = 16;
    localparam int BYTE_W = 8;

    // Byte order on the wire matches the RX assembly path: R, G, B
    localparam logic [1:0] BYTE_IDX_R = 2'd0;
    localparam logic [1:0] BYTE_IDX_G = 2'd1;
    localparam logic [1:0] BYTE_IDX_B = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_LATCH      = 3'd2,
        ST_SEND_START = 3'd3,
        ST_SEND_WAIT  = 3'd4,
        ST_NEXT       = 3'd5,
        ST_DONE       = 3'd6
    } tx_state_t;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic [BYTE_W-1:0] select_byte(input logic [PIX_W-1:0] pixel,
                                                      input logic [1:0]       idx);
        case (idx)
            BYTE_IDX_R: return pixel[23:16];
            BYTE_IDX_G: return pixel[15:8];
            default:    return pixel[7:0];
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_tx_disassembly_if.sv
// ============================================================================
// pixel_tx_disassembly_if : control, frame-buffer read port and UART line
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_tx_disassembly_if;
    import pixel_tx_disassembly_pkg::*;

    logic              start;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              tx;
    logic              busy;
    logic [ADDR_W-1:0] pixel_cnt;
    logic              frame_done;

    modport master (
        output start, rd_data,
        input  rd_en, rd_addr, tx, busy, pixel_cnt, frame_done
    );

    modport slave (
        input  start, rd_data,
        output rd_en, rd_addr, tx, busy, pixel_cnt, frame_done
    );

endinterface

`default_nettype wire

// File: rtl/pixel_tx_disassembly_uart_tx.sv
// ============================================================================
// pixel_tx_disassembly_uart_tx : 8N1 UART serialiser, registered tx output
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_tx_disassembly_uart_tx #(
    parameter int BIT_CYC = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [CNT_W-1:0] r_baud_cnt;
    logic [3:0]       r_bit_cnt;
    logic [8:0]       r_shift;
    logic             r_busy;
    logic             r_tx;
    logic             w_baud_end;

    assign w_baud_end = (r_baud_cnt == CNT_W'(BIT_CYC - 1));

    // bit 0 is the start bit, bits 1..8 data LSB first, bit 9 the stop bit
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 9'h1FF;
        end else if (!r_busy) begin
            if (tx_start) begin
                r_tx       <= 1'b0;
                r_shift    <= {1'b1, tx_data};
                r_busy     <= 1'b1;
                r_baud_cnt <= '0;
                r_bit_cnt  <= 4'd0;
            end
        end else if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 4'd9) begin
                r_busy <= 1'b0;
                r_tx   <= 1'b1;
            end else begin
                r_tx      <= r_shift[0];
                r_shift   <= {1'b1, r_shift[8:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + CNT_W'(1);
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_busy && (r_bit_cnt == 4'd9) && w_baud_end;

endmodule

`default_nettype wire

// File: rtl/pixel_tx_disassembly.sv
// ============================================================================
// pixel_tx_disassembly : streams a stored RGB frame out as R,G,B UART bytes
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_tx_disassembly
    import pixel_tx_disassembly_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int NUM_PIXELS = 40800
) (
    input  logic                   clk,
    input  logic                   reset,
    pixel_tx_disassembly_if.slave  bus
);

    localparam int               BIT_CYC    = bit_cycles(CLK_FREQ, BAUD);
    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(NUM_PIXELS - 1);

    tx_state_t         r_state;
    logic [PIX_W-1:0]  r_pixel;
    logic [1:0]        r_byte_idx;
    logic [ADDR_W-1:0] r_pixel_cnt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_tx_start;
    logic [BYTE_W-1:0] w_tx_byte;
    logic              w_tx_busy;
    logic              w_tx_done;

    assign w_tx_start = (r_state == ST_SEND_START) && !w_tx_busy;
    assign w_tx_byte  = select_byte(r_pixel, r_byte_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pixel      <= '0;
            r_byte_idx   <= BYTE_IDX_R;
            r_pixel_cnt  <= '0;
            r_rd_addr    <= '0;
            r_rd_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_FETCH;
                        r_pixel_cnt <= '0;
                        r_rd_addr   <= '0;
                        r_byte_idx  <= BYTE_IDX_R;
                        r_busy      <= 1'b1;
                        r_rd_en     <= 1'b1;
                    end
                end
                ST_FETCH: r_state <= ST_LATCH;
                // read data is valid exactly one cycle after the strobe
                ST_LATCH: begin
                    r_pixel <= bus.rd_data;
                    r_state <= ST_SEND_START;
                end
                ST_SEND_START: begin
                    if (!w_tx_busy) r_state <= ST_SEND_WAIT;
                end
                ST_SEND_WAIT: begin
                    if (w_tx_done) begin
                        if (r_byte_idx == BYTE_IDX_B) begin
                            r_byte_idx <= BYTE_IDX_R;
                            r_state    <= ST_NEXT;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_state    <= ST_SEND_START;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_pixel_cnt == LAST_PIXEL) begin
                        r_state      <= ST_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_pixel_cnt <= r_pixel_cnt + ADDR_W'(1);
                        r_rd_addr   <= r_pixel_cnt + ADDR_W'(1);
                        r_rd_en     <= 1'b1;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    pixel_tx_disassembly_uart_tx #(
        .BIT_CYC (BIT_CYC)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_start (w_tx_start),
        .tx_data  (w_tx_byte),
        .tx       (bus.tx),
        .tx_busy  (w_tx_busy),
        .tx_done  (w_tx_done)
    );

    assign bus.rd_en      = r_rd_en;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.busy       = r_busy;
    assign bus.pixel_cnt  = r_pixel_cnt;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire
